// File: rtl/regfile_scoreboard_if.sv
// Register file / scoreboard port bundle.
// The pipeline drives it as master; the register file is the slave.
interface regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     mark_en;
  logic [ADDR_W-1:0]        mark_addr;
  logic                     flush;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_ready;
  logic [ADDR_W:0]          busy_cnt;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    output mark_en,
    output mark_addr,
    output flush,
    output rd_addr,
    input  rd_data,
    input  rd_ready,
    input  busy_cnt
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  mark_en,
    input  mark_addr,
    input  flush,
    input  rd_addr,
    output rd_data,
    output rd_ready,
    output busy_cnt
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with per-register busy scoreboard.
// Reads are combinational; writes, marks and flushes land on the clock edge.
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input logic                 clk,
  input logic                 rst,
  regfile_scoreboard_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam bit BYP   = (BYPASS != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   cnt_nxt;

  logic wr_hit;
  logic mk_hit;

  logic [ADDR_W-1:0] ra  [NUM_RD];
  logic              zr  [NUM_RD];
  logic              byp [NUM_RD];

  assign wr_hit = bus.wr_en   && (bus.wr_addr   != '0);
  assign mk_hit = bus.mark_en && (bus.mark_addr != '0);

  // Later assignments win: write-clear, then flush, then the new producer.
  always_comb begin
    busy_nxt = busy;
    if (wr_hit) begin
      busy_nxt[bus.wr_addr] = 1'b0;
    end
    if (bus.flush) begin
      busy_nxt = '0;
    end
    if (mk_hit) begin
      busy_nxt[bus.mark_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        regs[k] <= '0;
      end
      busy  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_hit) begin
        regs[bus.wr_addr] <= bus.wr_data;
      end
      busy  <= busy_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  assign bus.busy_cnt = cnt_q;

  always_comb begin
    bus.rd_data  = '0;
    bus.rd_ready = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra[i]  = bus.rd_addr[i*ADDR_W +: ADDR_W];
      zr[i]  = (ra[i] == '0);
      byp[i] = BYP && wr_hit && !zr[i] &&
               (bus.wr_addr == ra[i]);
      unique case (1'b1)
        zr[i]: begin
          bus.rd_data[i*DATA_W +: DATA_W] = '0;
          bus.rd_ready[i] = 1'b1;
        end
        byp[i]: begin
          bus.rd_data[i*DATA_W +: DATA_W] = bus.wr_data;
          bus.rd_ready[i] = 1'b1;
        end
        default: begin
          bus.rd_data[i*DATA_W +: DATA_W] = regs[ra[i]];
          bus.rd_ready[i] = ~busy[ra[i]];
        end
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard, bypass and non-bypass
// instances driven side by side.
module tb_regfile_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ifa ();
  regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ifb ();

  assign ifb.wr_en     = ifa.wr_en;
  assign ifb.wr_addr   = ifa.wr_addr;
  assign ifb.wr_data   = ifa.wr_data;
  assign ifb.mark_en   = ifa.mark_en;
  assign ifb.mark_addr = ifa.mark_addr;
  assign ifb.flush     = ifa.flush;
  assign ifb.rd_addr   = ifa.rd_addr;

  regfile_scoreboard #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1)
  ) u_byp (
    .clk(clk), .rst(rst), .bus(ifa.slave)
  );

  regfile_scoreboard #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0)
  ) u_nob (
    .clk(clk), .rst(rst), .bus(ifb.slave)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        me;
    logic [4:0]  ma;
    logic        fl;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] b0;
    logic [31:0] b1;
    logic [1:0]  br;
    logic [31:0] n0;
    logic [31:0] n1;
    logic [1:0]  nr;
    logic [5:0]  cnt;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(
    logic we, logic [4:0] wa, logic [31:0] wd,
    logic me, logic [4:0] ma, logic fl,
    logic [4:0] r0, logic [4:0] r1,
    logic [31:0] b0, logic [31:0] b1, logic [1:0] br,
    logic [31:0] n0, logic [31:0] n1, logic [1:0] nr,
    logic [5:0] cnt);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd;
    v.me = me; v.ma = ma; v.fl = fl;
    v.r0 = r0; v.r1 = r1;
    v.b0 = b0; v.b1 = b1; v.br = br;
    v.n0 = n0; v.n1 = n1; v.nr = nr;
    v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic we, logic [4:0] wa, logic [31:0] wd,
                       logic me, logic [4:0] ma, logic fl,
                       logic [4:0] r0, logic [4:0] r1);
    ifa.wr_en     = we;
    ifa.wr_addr   = wa;
    ifa.wr_data   = wd;
    ifa.mark_en   = me;
    ifa.mark_addr = ma;
    ifa.flush     = fl;
    ifa.rd_addr   = {r1, r0};
  endtask

  task automatic idle(logic [4:0] r0, logic [4:0] r1);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, r0, r1);
  endtask

  initial begin
    // we wa wd me ma fl r0 r1 | byp d0 d1 rdy | nob d0 d1 rdy | cnt
    tbl.push_back(mk(0,0,0,           0,0,0, 3,0,  0,0,2'b11,           0,0,2'b11, 0));
    tbl.push_back(mk(1,9,32'hDEADBEEF,0,0,0, 9,0,  32'hDEADBEEF,0,2'b11, 0,0,2'b11, 0));
    tbl.push_back(mk(0,0,0,           0,0,0, 9,9,  32'hDEADBEEF,32'hDEADBEEF,2'b11,
                                               32'hDEADBEEF,32'hDEADBEEF,2'b11, 0));
    tbl.push_back(mk(0,0,0,           1,10,0,10,9, 0,32'hDEADBEEF,2'b11, 0,32'hDEADBEEF,2'b11, 1));
    tbl.push_back(mk(0,0,0,           0,0,0, 10,0, 0,0,2'b10,           0,0,2'b10, 1));
    tbl.push_back(mk(1,10,30,         0,0,0, 10,10,30,30,2'b11,         0,0,2'b00, 0));
    tbl.push_back(mk(0,0,0,           0,0,0, 10,10,30,30,2'b11,         30,30,2'b11, 0));
    tbl.push_back(mk(1,5,7,           1,5,0, 5,0,  7,0,2'b11,           0,0,2'b11, 1));
    tbl.push_back(mk(0,0,0,           0,0,0, 5,5,  7,7,2'b00,           7,7,2'b00, 1));
    tbl.push_back(mk(1,5,7,           0,0,0, 1,2,  0,0,2'b11,           0,0,2'b11, 0));
    tbl.push_back(mk(0,0,0,           1,1,0, 1,2,  0,0,2'b11,           0,0,2'b11, 1));
    tbl.push_back(mk(0,0,0,           1,2,0, 1,2,  0,0,2'b10,           0,0,2'b10, 2));
    tbl.push_back(mk(0,0,0,           1,3,0, 2,3,  0,0,2'b10,           0,0,2'b10, 3));
    tbl.push_back(mk(0,0,0,           1,4,1, 3,4,  0,0,2'b10,           0,0,2'b10, 1));
    tbl.push_back(mk(0,0,0,           0,0,0, 1,4,  0,0,2'b01,           0,0,2'b01, 1));
    tbl.push_back(mk(0,0,0,           0,0,0, 2,3,  0,0,2'b11,           0,0,2'b11, 1));
    tbl.push_back(mk(1,0,32'h55,      1,0,0, 0,0,  0,0,2'b11,           0,0,2'b11, 1));
    tbl.push_back(mk(0,0,0,           0,0,0, 0,4,  0,0,2'b01,           0,0,2'b01, 1));
    tbl.push_back(mk(0,0,0,           1,6,0, 6,6,  0,0,2'b11,           0,0,2'b11, 2));
    tbl.push_back(mk(1,6,32'h1234,    0,0,1, 6,0,  32'h1234,0,2'b11,    0,0,2'b10, 0));
    tbl.push_back(mk(0,0,0,           0,0,0, 6,9,  32'h1234,32'hDEADBEEF,2'b11,
                                               32'h1234,32'hDEADBEEF,2'b11, 0));

    idle(5'd0, 5'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_cnt_byp", 64'(ifa.busy_cnt), 64'd0);
    chk("reset_cnt_nob", 64'(ifb.busy_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[n]) begin
      vec_t v;
      v = tbl[n];
      @(negedge clk);
      drive(v.we, v.wa, v.wd, v.me, v.ma, v.fl, v.r0, v.r1);
      #1;
      chk($sformatf("v%0d_byp_d0", n), 64'(ifa.rd_data[31:0]),  64'(v.b0));
      chk($sformatf("v%0d_byp_d1", n), 64'(ifa.rd_data[63:32]), 64'(v.b1));
      chk($sformatf("v%0d_byp_rdy", n), 64'(ifa.rd_ready),      64'(v.br));
      chk($sformatf("v%0d_nob_d0", n), 64'(ifb.rd_data[31:0]),  64'(v.n0));
      chk($sformatf("v%0d_nob_d1", n), 64'(ifb.rd_data[63:32]), 64'(v.n1));
      chk($sformatf("v%0d_nob_rdy", n), 64'(ifb.rd_ready),      64'(v.nr));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_byp_cnt", n), 64'(ifa.busy_cnt), 64'(v.cnt));
      chk($sformatf("v%0d_nob_cnt", n), 64'(ifb.busy_cnt), 64'(v.cnt));
    end

    // Reset while marks are pending, with a write and mark in the same cycle.
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 5'd7, 5'd8);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 1'b0, 5'd7, 5'd8);
    @(negedge clk);
    idle(5'd7, 5'd8);
    #1;
    chk("pre_rst_cnt", 64'(ifa.busy_cnt), 64'd2);
    chk("pre_rst_rdy", 64'(ifa.rd_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 5'd12, 32'hCAFE, 1'b1, 5'd11, 1'b0, 5'd7, 5'd8);
    @(posedge clk);
    #1;
    chk("rst_cnt_byp", 64'(ifa.busy_cnt), 64'd0);
    chk("rst_cnt_nob", 64'(ifb.busy_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(5'd7, 5'd8);
    #1;
    chk("post_rst_rdy78", 64'(ifa.rd_ready), 64'b11);
    ifa.rd_addr = {5'd10, 5'd9};
    #1;
    chk("post_rst_r9", 64'(ifa.rd_data[31:0]),  64'd0);
    chk("post_rst_r10", 64'(ifa.rd_data[63:32]), 64'd0);
    ifa.rd_addr = {5'd12, 5'd6};
    #1;
    chk("post_rst_r6", 64'(ifb.rd_data[31:0]),  64'd0);
    chk("post_rst_r12", 64'(ifb.rd_data[63:32]), 64'd0);
    ifa.rd_addr = {5'd11, 5'd5};
    #1;
    chk("post_rst_r5", 64'(ifa.rd_data[31:0]), 64'd0);
    chk("post_rst_rdy", 64'(ifa.rd_ready), 64'b11);
    @(posedge clk);
    #1;
    chk("post_rst_cnt", 64'(ifa.busy_cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
